memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares the single-port unified RAM between instruction fetch and the data path.
- Inputs come from the control unit's iREN/dREN/dWEN/datomic strobes, via the datapath.
- Serialises accesses with a small FSM: data has priority, and a fairness flag prevents fetch starvation.
- Owns the LL/SC link register, so it resolves store-conditional success.

Parameters:
ADDR_W, 32, word-aligned byte address width
DATA_W, 32, data word width

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, synchronous, active-high
iREN  in  1  instruction fetch request
iaddr  in  ADDR_W  fetch address
iwait  out  1  1 = fetch not complete this cycle
iload  out  DATA_W  fetched word, valid when iREN & !iwait
dREN  in  1  data read request (LW/LL)
dWEN  in  1  data write request (SW/SC)
datomic  in  1  qualifies dREN as LL, dWEN as SC
daddr  in  ADDR_W  data address
dstore  in  DATA_W  write data
dwait  out  1  1 = data access not complete this cycle
dload  out  DATA_W  read data, or SC result (1 success / 0 fail)
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data, valid with ram_ack
ram_ack  in  1  RAM completes the current access this cycle

Behaviour:
- The interface has one clock, CLK. Reset RST is synchronous and active-high: on a rising CLK edge with RST=1, all state is cleared.
- Reset values:
  - state=IDLE, ramREN=ramWEN=0, ramaddr=ramstore=0.
  - link_valid=0, link_addr=0, i_next=0.
  - iwait=iREN, dwait=(dREN|dWEN), iload=dload=0.
- States: IDLE, IFETCH, DACCESS, SCFAIL.
- IDLE (the RAM strobes are always 0 here):
  - A data request is pending if dREN|dWEN.
  - A fetch request is pending if iREN.
  - If both are pending and i_next=1, go to IFETCH. Otherwise, with both pending, go to DACCESS.
  - If only one is pending, go to its state.
  - SC with (!link_valid | link_addr!=daddr) goes to SCFAIL instead of DACCESS.
  - On entry to IFETCH or DACCESS, latch address and data into internal registers.
- IFETCH:
  - Drive ramREN=1 and ramaddr=latched iaddr.
  - On ram_ack: iwait=0, iload=ramload, i_next<=0, go to IDLE.
- DACCESS:
  - Drive ramREN or ramWEN from the latched request type, plus the latched ramaddr and ramstore.
  - On ram_ack: dwait=0, go to IDLE.
  - On ram_ack, i_next<=iREN.
  - On ram_ack, set dload:
    - LW/LL: dload=ramload.
    - SW: dload=0.
    - SC: dload=1.
- SCFAIL: no RAM strobe; dwait=0 and dload=0 for exactly 1 cycle, then go to IDLE. i_next<=iREN.
- Wait/data outputs:
  - iwait=iREN & !(state==IFETCH & ram_ack).
  - dwait=(dREN|dWEN) & !((state==DACCESS & ram_ack) | state==SCFAIL).
  - iload and dload are 0 whenever the matching wait is not low.
- Latency: request seen in IDLE at cycle N; RAM strobe at N+1; earliest wait low at N+1 (ram_ack same cycle). Minimum 2 cycles per access.
- Link register, updated at access completion only:
  - LL: link_valid<=1, link_addr<=daddr.
  - Successful SC: link_valid<=0.
  - Plain SW with daddr==link_addr: link_valid<=0.
  - LW and fetches: no effect.
- Requesters hold address/data/strobe until their wait is low.
  - A request dropped mid-access still completes at the RAM; the result is discarded.
  - The state still returns to IDLE on ram_ack.
- dREN and dWEN both high: treated as a write.
- RST mid-access: IDLE on the next edge, strobes 0 immediately that cycle, link cleared; an outstanding RAM ack is ignored.
- ram_ack in IDLE/SCFAIL: ignored.

Test Plan:
1. Isolated fetch: iREN=1, iaddr=0x40, ram_ack on 2nd cycle with ramload=0x3C01_0004 -> ramREN=1/ramaddr=0x40 from cycle 1, iwait low and iload=0x3C01_0004 in cycle 2, then IDLE.
2. Contention with fairness: iREN=1 and dREN=1 (daddr=0x100) together -> DACCESS first; then IFETCH serviced even though dREN is re-asserted immediately; a third request goes to data again.
3. LL/SC success: LL 0x200, then SC 0x200 with dstore=0xDEAD -> ramWEN=1, ramstore=0xDEAD, dload=1, link_valid=0 after completion.
4. SC fail: LL 0x200, SW 0x200 (clears link), SC 0x200 -> SCFAIL, no ramWEN asserted, dload=0, dwait low exactly 1 cycle.
5. Reset mid-access: assert RST while in DACCESS before ram_ack -> ramREN/ramWEN=0 and state=IDLE next cycle; a subsequent SC 0x200 fails.
6. Simultaneous dREN&dWEN with ram_ack held high -> write performed (ramWEN=1, ramREN=0), dload=0, 2-cycle completion.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Bundle of requester handshakes (fetch and data) and the single-port RAM
// signals shared by the unified-memory arbiter.
interface memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic              datomic;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ram_ack;

    // Arbiter side: serves the requesters and masters the RAM.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ram_ack,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Environment side: requesters plus the RAM itself.
    modport master (
        output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ram_ack,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/memory_arbiter.sv
// Serialises instruction fetch and data accesses onto one single-port RAM with
// data priority, a fetch fairness flag and the LL/SC link register.
module memory_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic             CLK,
    input logic             RST,
    memory_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IFETCH  = 2'd1,
        DACCESS = 2'd2,
        SCFAIL  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] link_addr_r;
    logic [DATA_W-1:0] store_r;
    logic              wr_r;
    logic              atomic_r;
    logic              link_valid_r;
    logic              i_next_r;
    logic              d_pend_s;
    logic              sc_fail_s;
    logic              latch_i_s;
    logic              latch_d_s;
    logic              i_done_s;
    logic              d_done_s;

    // Next-state selection and request latching strobes
    always_comb begin
        d_pend_s     = bus.dREN | bus.dWEN;
        sc_fail_s    = bus.dWEN & bus.datomic & (~link_valid_r | (link_addr_r != bus.daddr));
        state_next_s = state_r;
        latch_i_s    = 1'b0;
        latch_d_s    = 1'b0;
        case (state_r)
            IDLE: begin
                // Data wins unless fetch is owed a turn after the previous data access.
                if (d_pend_s && !(bus.iREN && i_next_r)) begin
                    if (sc_fail_s) begin
                        state_next_s = SCFAIL;
                    end else begin
                        state_next_s = DACCESS;
                        latch_d_s    = 1'b1;
                    end
                end else if (bus.iREN) begin
                    state_next_s = IFETCH;
                    latch_i_s    = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            IFETCH, DACCESS: begin
                if (bus.ram_ack) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            SCFAIL:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register, latched request and fetch fairness flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= IDLE;
            addr_r   <= {ADDR_W{1'b0}};
            store_r  <= {DATA_W{1'b0}};
            wr_r     <= 1'b0;
            atomic_r <= 1'b0;
            i_next_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (latch_i_s) begin
                addr_r   <= bus.iaddr;
                store_r  <= {DATA_W{1'b0}};
                wr_r     <= 1'b0;
                atomic_r <= 1'b0;
            end else if (latch_d_s) begin
                addr_r   <= bus.daddr;
                store_r  <= bus.dstore;
                wr_r     <= bus.dWEN;
                atomic_r <= bus.datomic;
            end
            if (state_r == IFETCH && bus.ram_ack) begin
                i_next_r <= 1'b0;
            end else if ((state_r == DACCESS && bus.ram_ack) || state_r == SCFAIL) begin
                i_next_r <= bus.iREN;
            end
        end
    end

    // LL/SC link, touched only when a data access completes at the RAM
    always_ff @(posedge CLK) begin
        if (RST) begin
            link_valid_r <= 1'b0;
            link_addr_r  <= {ADDR_W{1'b0}};
        end else if (state_r == DACCESS && bus.ram_ack) begin
            if (!wr_r && atomic_r) begin
                link_valid_r <= 1'b1;
                link_addr_r  <= addr_r;
            end else if (wr_r && (atomic_r || addr_r == link_addr_r)) begin
                link_valid_r <= 1'b0;
            end
        end
    end

    // RAM strobes follow the state; reset forces them low within the same cycle
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = {ADDR_W{1'b0}};
        bus.ramstore = {DATA_W{1'b0}};
        if (!RST && state_r == IFETCH) begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = addr_r;
        end else if (!RST && state_r == DACCESS) begin
            bus.ramREN   = ~wr_r;
            bus.ramWEN   = wr_r;
            bus.ramaddr  = addr_r;
            bus.ramstore = wr_r ? store_r : {DATA_W{1'b0}};
        end else begin
            bus.ramREN = 1'b0;
            bus.ramWEN = 1'b0;
        end
    end

    // Requester handshakes; a stray ram_ack outside an access state is ignored
    always_comb begin
        i_done_s  = !RST && state_r == IFETCH && bus.ram_ack;
        d_done_s  = !RST && ((state_r == DACCESS && bus.ram_ack) || state_r == SCFAIL);
        bus.iwait = bus.iREN & ~i_done_s;
        bus.iload = (bus.iREN && i_done_s) ? bus.ramload : {DATA_W{1'b0}};
        bus.dwait = d_pend_s & ~d_done_s;
        if (d_pend_s && d_done_s && state_r == DACCESS) begin
            bus.dload = wr_r ? {{(DATA_W-1){1'b0}}, atomic_r} : bus.ramload;
        end else begin
            bus.dload = {DATA_W{1'b0}};
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios and random traffic scored against
// a transaction-level model of grant order, completion time, results and the LL/SC link.
module tb_memory_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int K_LW = 0;
    localparam int K_SW = 1;
    localparam int K_LL = 2;
    localparam int K_SC = 3;

    typedef struct {
        int          kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit          both;
    } dop_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] ref_mem [256];
    bit            m_link_valid;
    logic [AW-1:0] m_link_addr;
    bit            m_fair;
    bit            ack_always;
    dop_t          dq [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_d(input dop_t op, input bit en);
        bus.dREN    = en && (op.kind == K_LW || op.kind == K_LL || op.both);
        bus.dWEN    = en && (op.kind == K_SW || op.kind == K_SC);
        bus.datomic = en && (op.kind == K_LL || op.kind == K_SC);
        bus.daddr   = op.addr;
        bus.dstore  = op.wdata;
    endtask

    task automatic idle_inputs();
        bus.iREN    = 1'b0;
        bus.iaddr   = 32'h0;
        bus.dREN    = 1'b0;
        bus.dWEN    = 1'b0;
        bus.datomic = 1'b0;
        bus.daddr   = 32'h0;
        bus.dstore  = 32'h0;
        bus.ram_ack = 1'b0;
        bus.ramload = 32'h0;
    endtask

    task automatic push(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input bit both);
        dop_t op;
        op.kind  = kind;
        op.addr  = addr;
        op.wdata = wdata;
        op.both  = both;
        dq.push_back(op);
    endtask

    task automatic reset_check(input bit ireq, input bit dreq);
        dop_t op;
        op.kind  = K_LW;
        op.addr  = 32'h100;
        op.wdata = 32'h0;
        op.both  = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        bus.iREN  = ireq;
        bus.iaddr = 32'h40;
        drive_d(op, dreq);
        bus.ram_ack = 1'b0;
        @(negedge CLK);
        #1;
        chk("rst_strobes", {bus.ramREN, bus.ramWEN}, 2'b00);
        chk("rst_ramaddr", bus.ramaddr, 32'h0);
        chk("rst_ramstore", bus.ramstore, 32'h0);
        chk("rst_iwait", bus.iwait, ireq);
        chk("rst_dwait", bus.dwait, dreq);
        chk("rst_iload", bus.iload, 32'h0);
        chk("rst_dload", bus.dload, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        idle_inputs();
        m_link_valid = 1'b0;
        m_link_addr  = 32'h0;
        m_fair       = 1'b0;
    endtask

    // One optional fetch plus the queued data ops (each presented as soon as the previous completes).
    task automatic run(input bit do_i, input logic [AW-1:0] ia, input int lat);
        bit            i_act, d_act, idle, was_idle, serv_d, scf, done_now, wr;
        int            cyc, done_cyc, strobe_cnt;
        dop_t          cur;
        logic [1:0]    exp_strb;
        logic [DW-1:0] exp_dload;
        idle       = 1'b1;
        cyc        = 0;
        done_cyc   = 0;
        strobe_cnt = 0;
        serv_d     = 1'b0;
        scf        = 1'b0;
        cur.kind   = K_LW;
        cur.addr   = 32'h0;
        cur.wdata  = 32'h0;
        cur.both   = 1'b0;
        @(negedge CLK);
        i_act     = do_i;
        bus.iREN  = do_i;
        bus.iaddr = ia;
        d_act     = (dq.size() > 0);
        if (d_act) cur = dq.pop_front();
        drive_d(cur, d_act);
        while ((i_act || d_act) && cyc < 60) begin
            strobe_cnt  = (bus.ramREN || bus.ramWEN) ? strobe_cnt + 1 : 0;
            bus.ram_ack = ack_always || (strobe_cnt > lat);
            bus.ramload = bus.ramREN ? ram_mem[bus.ramaddr[9:2]] : DW'($urandom);
            if (bus.ramWEN && bus.ram_ack) ram_mem[bus.ramaddr[9:2]] = bus.ramstore;
            #1;
            was_idle = idle;
            wr = (cur.kind == K_SW) || (cur.kind == K_SC);
            if (was_idle) begin
                serv_d   = d_act && !(i_act && m_fair);
                scf      = serv_d && cur.kind == K_SC && !(m_link_valid && m_link_addr == cur.addr);
                done_cyc = cyc + 1 + (scf ? 0 : lat);
                idle     = 1'b0;
                chk("idle_strobes", {bus.ramREN, bus.ramWEN}, 2'b00);
            end else begin
                exp_strb = !serv_d ? 2'b10 : (scf ? 2'b00 : (wr ? 2'b01 : 2'b10));
                chk("strobes", {bus.ramREN, bus.ramWEN}, exp_strb);
                if (exp_strb != 2'b00) chk("ramaddr", bus.ramaddr, serv_d ? cur.addr : ia);
                if (exp_strb == 2'b01) chk("ramstore", bus.ramstore, cur.wdata);
            end
            done_now  = !was_idle && cyc == done_cyc;
            exp_dload = 32'h0;
            if (done_now && serv_d) begin
                case (cur.kind)
                    K_LW, K_LL: exp_dload = ref_mem[cur.addr[9:2]];
                    K_SC:       exp_dload = scf ? 32'h0 : 32'h1;
                    default:    exp_dload = 32'h0;
                endcase
            end
            chk("iwait", bus.iwait, i_act && !(done_now && !serv_d));
            chk("dwait", bus.dwait, d_act && !(done_now && serv_d));
            chk("iload", bus.iload, (done_now && !serv_d) ? ref_mem[ia[9:2]] : 32'h0);
            chk("dload", bus.dload, exp_dload);
            if (done_now) begin
                idle = 1'b1;
                if (serv_d) begin
                    if (cur.kind == K_LL) begin
                        m_link_valid = 1'b1;
                        m_link_addr  = cur.addr;
                    end else if (cur.kind == K_SW) begin
                        ref_mem[cur.addr[9:2]] = cur.wdata;
                        if (m_link_addr == cur.addr) m_link_valid = 1'b0;
                    end else if (cur.kind == K_SC && !scf) begin
                        ref_mem[cur.addr[9:2]] = cur.wdata;
                        m_link_valid = 1'b0;
                    end
                    m_fair = i_act;
                end else begin
                    m_fair = 1'b0;
                end
            end
            cyc++;
            @(negedge CLK);
            if (done_now && !serv_d) begin
                i_act    = 1'b0;
                bus.iREN = 1'b0;
            end
            if (done_now && serv_d) begin
                d_act = (dq.size() > 0);
                if (d_act) cur = dq.pop_front();
                drive_d(cur, d_act);
            end
        end
        bus.ram_ack = ack_always;
    endtask

    initial begin
        int nd;
        bit di;
        ack_always   = 1'b0;
        m_link_valid = 1'b0;
        m_link_addr  = 32'h0;
        m_fair       = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = $urandom;
            ref_mem[i] = ram_mem[i];
        end
        idle_inputs();
        reset_check(1'b1, 1'b1);

        // Isolated fetch with a one-cycle RAM delay.
        ram_mem[16] = 32'h3C01_0004;
        ref_mem[16] = 32'h3C01_0004;
        run(1'b1, 32'h40, 1);

        // Contention: data first, fetch owed a turn despite data re-asserting, then data again.
        push(K_LW, 32'h100, 32'h0, 1'b0);
        push(K_LW, 32'h104, 32'h0, 1'b0);
        push(K_LW, 32'h108, 32'h0, 1'b0);
        run(1'b1, 32'h80, 0);
        push(K_LW, 32'h100, 32'h0, 1'b0);
        run(1'b1, 32'h84, 2);

        // LL/SC success, then a repeated SC to the same line must fail.
        push(K_LL, 32'h200, 32'h0, 1'b0);
        push(K_SC, 32'h200, 32'h0000_DEAD, 1'b0);
        push(K_SC, 32'h200, 32'h0000_BEEF, 1'b0);
        push(K_LW, 32'h200, 32'h0, 1'b0);
        run(1'b0, 32'h0, 1);

        // SC fail after an intervening SW; back-to-back SCs show dwait low only one cycle.
        push(K_LL, 32'h200, 32'h0, 1'b0);
        push(K_SW, 32'h200, 32'h0000_1234, 1'b0);
        push(K_SC, 32'h200, 32'h0000_5678, 1'b0);
        push(K_SC, 32'h200, 32'h0000_9ABC, 1'b0);
        push(K_LW, 32'h200, 32'h0, 1'b0);
        run(1'b0, 32'h0, 0);

        // Reset while a store is in flight: strobes drop at once, link is cleared.
        push(K_LL, 32'h200, 32'h0, 1'b0);
        run(1'b0, 32'h0, 0);
        @(negedge CLK);
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h200;
        bus.dstore = 32'h7777_0000;
        bus.ram_ack = 1'b0;
        @(negedge CLK);
        #1;
        chk("mid_wen", bus.ramWEN, 1'b1);
        @(negedge CLK);
        RST = 1'b1;
        bus.ram_ack = 1'b1;
        #1;
        chk("mid_rst_strobes", {bus.ramREN, bus.ramWEN}, 2'b00);
        chk("mid_rst_dwait", bus.dwait, 1'b1);
        @(negedge CLK);
        RST = 1'b0;
        idle_inputs();
        #1;
        chk("post_rst_strobes", {bus.ramREN, bus.ramWEN}, 2'b00);
        m_link_valid = 1'b0;
        m_fair       = 1'b0;
        push(K_SC, 32'h200, 32'h0000_5555, 1'b0);
        push(K_LW, 32'h200, 32'h0, 1'b0);
        run(1'b0, 32'h0, 1);

        // dREN and dWEN together with ram_ack stuck high: a write, two-cycle completion.
        ack_always = 1'b1;
        push(K_SW, 32'h300, 32'hCAFE_F00D, 1'b1);
        run(1'b0, 32'h0, 0);
        ack_always  = 1'b0;
        bus.ram_ack = 1'b0;
        push(K_LW, 32'h300, 32'h0, 1'b0);
        run(1'b0, 32'h0, 0);

        // Random traffic on a small address window so LL/SC links collide.
        for (int n = 0; n < 40; n++) begin
            nd = $urandom_range(0, 2);
            for (int k = 0; k < nd; k++) begin
                push(int'($urandom_range(0, 3)), 32'h200 + 32'($urandom_range(0, 3)) * 32'd4,
                     $urandom, 1'($urandom_range(0, 1)));
            end
            di = (nd == 0) || ($urandom_range(0, 1) == 1);
            run(di, 32'($urandom_range(0, 63)) * 32'd4, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
